// File: rtl/fft_out_reorder.sv
// Bit-reversed to natural-order reorder buffer for the 4-lane FFT output, ping-pong banked.
// Optional sticky sof_err output when FFT_REORDER_SOFERR_EN is defined.
module fft_out_reorder #(
   parameter int unsigned NBITS_OUT = 19,
   parameter int unsigned N         = 128
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic                   in_sof,
   input  logic [2*NBITS_OUT-1:0] fftIn0_up,
   input  logic [2*NBITS_OUT-1:0] fftIn0_down,
   input  logic [2*NBITS_OUT-1:0] fftIn1_up,
   input  logic [2*NBITS_OUT-1:0] fftIn1_down,
   output logic                   out_valid,
   output logic                   out_sof,
   output logic [2*NBITS_OUT-1:0] fftOut0,
   output logic [2*NBITS_OUT-1:0] fftOut1,
   output logic [2*NBITS_OUT-1:0] fftOut2,
   output logic [2*NBITS_OUT-1:0] fftOut3
`ifdef FFT_REORDER_SOFERR_EN
   ,
   output logic                   sof_err
`endif
);

   localparam int unsigned DW = 2 * NBITS_OUT;
   localparam int unsigned AW = $clog2(N);
   localparam int unsigned BW = AW - 2;
   localparam int unsigned B  = N / 4;

   typedef enum logic {IDLE, READ} state_t;

   logic [DW-1:0] mem [2*N];
   logic [BW-1:0] wptr;
   logic [BW-1:0] rptr;
   logic [BW-1:0] wbeat;
   logic          wbank;
   logic          rbank;
   logic [1:0]    full;
   logic [1:0]    full_set;
   logic [1:0]    full_clr;
   logic          wlast;
   logic          rlast;
   state_t        state;

   function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
      logic [AW-1:0] r;
      for (int unsigned i = 0; i < AW; i++) r[i] = x[AW-1-i];
      return r;
   endfunction

   function automatic logic [AW:0] waddr(input logic bank, input logic [BW-1:0] beat,
                                         input logic [1:0] lane);
      return {bank, bitrev({beat, lane})};
   endfunction

   // An in_sof beat always lands as beat 0, discarding any partial frame in the bank.
   assign wbeat = in_sof ? '0 : wptr;
   assign wlast = (wbeat == BW'(B - 1));
   assign rlast = (rptr == BW'(B - 1));

   always_comb begin
      full_set = '0;
      full_clr = '0;
      if (in_valid && wlast) full_set[wbank] = 1'b1;
      if (state == READ && rlast) full_clr[rbank] = 1'b1;
   end

   // Scatter each input sample to its natural-order address.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         mem[waddr(wbank, wbeat, 2'd0)] <= fftIn0_up;
         mem[waddr(wbank, wbeat, 2'd1)] <= fftIn0_down;
         mem[waddr(wbank, wbeat, 2'd2)] <= fftIn1_up;
         mem[waddr(wbank, wbeat, 2'd3)] <= fftIn1_down;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wptr      <= '0;
         rptr      <= '0;
         wbank     <= 1'b0;
         rbank     <= 1'b0;
         full      <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         fftOut0   <= '0;
         fftOut1   <= '0;
         fftOut2   <= '0;
         fftOut3   <= '0;
      end else begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         full      <= (full & ~full_clr) | full_set;
         if (in_valid) begin
            if (wlast) begin
               wptr  <= '0;
               wbank <= ~wbank;
            end else begin
               wptr <= wbeat + BW'(1);
            end
         end
         case (state)
            IDLE: begin
               if (full[rbank]) begin
                  state <= READ;
                  rptr  <= '0;
               end
            end
            READ: begin
               out_valid <= 1'b1;
               out_sof   <= (rptr == '0);
               fftOut0   <= mem[{rbank, rptr, 2'd0}];
               fftOut1   <= mem[{rbank, rptr, 2'd1}];
               fftOut2   <= mem[{rbank, rptr, 2'd2}];
               fftOut3   <= mem[{rbank, rptr, 2'd3}];
               rptr      <= rptr + BW'(1);
               // Banks fill alternately, so the next frame to read is always in the other bank.
               if (rlast) begin
                  rbank <= ~rbank;
                  rptr  <= '0;
                  if (!full[~rbank]) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FFT_REORDER_SOFERR_EN
   always_ff @(posedge clk) begin
      if (rst) sof_err <= 1'b0;
      else if (in_valid && in_sof && (wptr != '0)) sof_err <= 1'b1;
   end
`endif

   // Writing into a bank that is still waiting to be read (and not freed this edge) is an overrun.
   a_no_overrun: assert property (@(posedge clk) disable iff (rst)
      in_valid |-> (!full[wbank] || (state == READ && rbank == wbank && rlast)));

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder: randomized frames checked against a bin-order model.
module tb_fft_out_reorder;

   localparam int NB   = 19;
   localparam int N    = 128;
   localparam int B    = N / 4;
   localparam int LOG2 = 7;
   localparam int DW   = 2 * NB;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_sof;
   logic [DW-1:0] in0, in1, in2, in3;
   logic          out_valid;
   logic          out_sof;
   logic [DW-1:0] o0, o1, o2, o3;
`ifdef FFT_REORDER_SOFERR_EN
   logic          sof_err;
`endif

   fft_out_reorder #(.NBITS_OUT(NB), .N(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
      .fftIn0_up(in0), .fftIn0_down(in1), .fftIn1_up(in2), .fftIn1_down(in3),
      .out_valid(out_valid), .out_sof(out_sof),
      .fftOut0(o0), .fftOut1(o1), .fftOut2(o2), .fftOut3(o3)
`ifdef FFT_REORDER_SOFERR_EN
      , .sof_err(sof_err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   int last_edge = 0;

   // Frames indexed by input position p = 4*beat + lane.
   logic [DW-1:0]   fr [3][N];
   logic [4*DW-1:0] obs_d [$];
   logic            obs_s [$];
   int              obs_t [$];

   always @(negedge clk) begin
      if (out_valid) begin
         obs_d.push_back({o3, o2, o1, o0});
         obs_s.push_back(out_sof);
         obs_t.push_back(cyc);
      end
   end

   function automatic int brev(input int p);
      int r = 0;
      for (int i = 0; i < LOG2; i++) if (((p >> i) & 1) != 0) r = r | (1 << (LOG2 - 1 - i));
      return r;
   endfunction

   function automatic logic [DW-1:0] cpx(input int re, input int im);
      return {NB'(re), NB'(im)};
   endfunction

   // Natural-order output beat c of frame f carries bins 4c..4c+3; bin k sat at input position brev(k).
   function automatic logic [4*DW-1:0] exp_beat(input int f, input int c);
      return {fr[f][brev(4*c+3)], fr[f][brev(4*c+2)], fr[f][brev(4*c+1)], fr[f][brev(4*c)]};
   endfunction

   task automatic clear_obs();
      obs_d.delete();
      obs_s.delete();
      obs_t.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_sof   = 1'b0;
      end
   endtask

   task automatic drive_beat(input int f, input int c, input logic sof);
      @(negedge clk);
      in_valid  = 1'b1;
      in_sof    = sof;
      in0       = fr[f][4*c];
      in1       = fr[f][4*c+1];
      in2       = fr[f][4*c+2];
      in3       = fr[f][4*c+3];
      last_edge = cyc + 1;
   endtask

   // gap >= 0: fixed idle cycles after each beat; gap < 0: random 0..2.
   task automatic send_frame(input int f, input int gap, input logic sof);
      for (int c = 0; c < B; c++) begin
         drive_beat(f, c, sof && (c == 0));
         if (gap > 0) idle(gap);
         else if (gap < 0) idle(int'($urandom_range(0, 2)));
      end
      idle(1);
   endtask

   task automatic wait_out(input int n);
      int k = 0;
      while (obs_d.size() < n && k < 2000) begin
         @(negedge clk);
         k++;
      end
      repeat (8) @(negedge clk);
      n_tests++;
      if (obs_d.size() != n) begin
         n_fail++;
         $display("FAIL beat_count: got %0d beats, expected %0d", obs_d.size(), n);
      end
   endtask

   task automatic rand_frame(input int f);
      for (int p = 0; p < N; p++) fr[f][p] = DW'({$urandom, $urandom});
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
      in0 = '0; in1 = '0; in2 = '0; in3 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || out_sof !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: out_valid=%b out_sof=%b expected 0 0", out_valid, out_sof);
      end
      n_tests++;
      if ({o3, o2, o1, o0} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 0", {o3, o2, o1, o0});
      end
`ifdef FFT_REORDER_SOFERR_EN
      n_tests++;
      if (sof_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_sof_err: got %b expected 0", sof_err);
      end
`endif
   endtask

   task automatic test_single_frame();
      for (int p = 0; p < N; p++) fr[0][p] = cpx(brev(p), -brev(p));
      clear_obs();
      send_frame(0, 0, 1'b1);
      wait_out(B);
      n_tests++;
      if (obs_t.size() > 0 && obs_t[0] !== last_edge + 2) begin
         n_fail++;
         $display("FAIL single_latency: first beat at edge %0d expected %0d", obs_t[0], last_edge + 2);
      end
      for (int i = 0; i < obs_d.size() && i < B; i++) begin
         n_tests++;
         if (obs_d[i] !== exp_beat(0, i) || obs_s[i] !== (i == 0)) begin
            n_fail++;
            $display("FAIL single_beat%0d: got %h sof=%b expected %h sof=%b",
                     i, obs_d[i], obs_s[i], exp_beat(0, i), (i == 0));
         end
      end
      n_tests++;
      if (out_valid !== 1'b0 || {o3, o2, o1, o0} !== exp_beat(0, B - 1)) begin
         n_fail++;
         $display("FAIL single_hold: valid=%b data=%h expected 0 %h", out_valid, {o3, o2, o1, o0},
                  exp_beat(0, B - 1));
      end
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 3; f++)
         for (int p = 0; p < N; p++) fr[f][p] = cpx(brev(p) + 128 * f, -brev(p));
      clear_obs();
      for (int f = 0; f < 3; f++)
         for (int c = 0; c < B; c++) drive_beat(f, c, c == 0);
      idle(1);
      wait_out(3 * B);
      n_tests++;
      if (obs_t.size() > 0 && obs_t[0] !== last_edge + 2 - 2 * B) begin
         n_fail++;
         $display("FAIL b2b_latency: first beat at edge %0d expected %0d", obs_t[0], last_edge + 2 - 2 * B);
      end
      for (int i = 0; i < obs_d.size() && i < 3 * B; i++) begin
         n_tests++;
         if (obs_d[i] !== exp_beat(i / B, i % B) || obs_s[i] !== (i % B == 0) ||
             obs_t[i] !== obs_t[0] + i) begin
            n_fail++;
            $display("FAIL b2b_beat%0d: got %h sof=%b t=%0d expected %h sof=%b t=%0d", i, obs_d[i],
                     obs_s[i], obs_t[i], exp_beat(i / B, i % B), (i % B == 0), obs_t[0] + i);
         end
      end
   endtask

   task automatic test_gapped();
      for (int p = 0; p < N; p++) fr[0][p] = cpx(brev(p), -brev(p));
      clear_obs();
      for (int c = 0; c < B; c++) begin
         drive_beat(0, c, c == 0);
         idle(2);
      end
      wait_out(B);
      n_tests++;
      if (obs_t.size() > 0 && obs_t[0] !== last_edge + 2) begin
         n_fail++;
         $display("FAIL gapped_latency: first beat at edge %0d expected %0d", obs_t[0], last_edge + 2);
      end
      for (int i = 0; i < obs_d.size() && i < B; i++) begin
         n_tests++;
         if (obs_d[i] !== exp_beat(0, i) || obs_s[i] !== (i == 0)) begin
            n_fail++;
            $display("FAIL gapped_beat%0d: got %h sof=%b expected %h sof=%b",
                     i, obs_d[i], obs_s[i], exp_beat(0, i), (i == 0));
         end
      end
   endtask

   task automatic test_mid_sof();
      rand_frame(0);
      rand_frame(1);
      clear_obs();
      for (int c = 0; c < 10; c++) drive_beat(0, c, c == 0);
      send_frame(1, 0, 1'b1);
      wait_out(B);
      for (int i = 0; i < obs_d.size() && i < B; i++) begin
         n_tests++;
         if (obs_d[i] !== exp_beat(1, i) || obs_s[i] !== (i == 0)) begin
            n_fail++;
            $display("FAIL midsof_beat%0d: got %h sof=%b expected %h sof=%b",
                     i, obs_d[i], obs_s[i], exp_beat(1, i), (i == 0));
         end
      end
`ifdef FFT_REORDER_SOFERR_EN
      n_tests++;
      if (sof_err !== 1'b1) begin
         n_fail++;
         $display("FAIL midsof_sof_err: got %b expected 1", sof_err);
      end
`endif
   endtask

   task automatic test_reset_mid_frame();
      rand_frame(0);
      rand_frame(1);
      clear_obs();
      for (int c = 0; c < 20; c++) drive_beat(0, c, c == 0);
      @(negedge clk);
      in_valid = 1'b0; in_sof = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send_frame(1, -1, 1'b0);
      wait_out(B);
      n_tests++;
      if (obs_t.size() > 0 && obs_t[0] !== last_edge + 2) begin
         n_fail++;
         $display("FAIL rstmid_latency: first beat at edge %0d expected %0d", obs_t[0], last_edge + 2);
      end
      for (int i = 0; i < obs_d.size() && i < B; i++) begin
         n_tests++;
         if (obs_d[i] !== exp_beat(1, i) || obs_s[i] !== (i == 0)) begin
            n_fail++;
            $display("FAIL rstmid_beat%0d: got %h sof=%b expected %h sof=%b",
                     i, obs_d[i], obs_s[i], exp_beat(1, i), (i == 0));
         end
      end
`ifdef FFT_REORDER_SOFERR_EN
      n_tests++;
      if (sof_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_sof_err: got %b expected 0", sof_err);
      end
`endif
   endtask

   task automatic test_extremes();
      for (int p = 0; p < N; p++) begin
         fr[0][p] = {19'h3FFFF, 19'h40000};
         fr[1][p] = {19'h40000, 19'h3FFFF};
      end
      clear_obs();
      for (int f = 0; f < 2; f++)
         for (int c = 0; c < B; c++) drive_beat(f, c, c == 0);
      idle(1);
      wait_out(2 * B);
      for (int i = 0; i < obs_d.size() && i < 2 * B; i++) begin
         n_tests++;
         if (obs_d[i] !== exp_beat(i / B, i % B) || obs_s[i] !== (i % B == 0)) begin
            n_fail++;
            $display("FAIL extreme_beat%0d: got %h sof=%b expected %h sof=%b", i, obs_d[i],
                     obs_s[i], exp_beat(i / B, i % B), (i % B == 0));
         end
      end
   endtask

   task automatic test_random_gaps();
      rand_frame(0);
      rand_frame(1);
      clear_obs();
      send_frame(0, -1, 1'b1);
      send_frame(1, -1, 1'b0);
      wait_out(2 * B);
      for (int i = 0; i < obs_d.size() && i < 2 * B; i++) begin
         n_tests++;
         if (obs_d[i] !== exp_beat(i / B, i % B) || obs_s[i] !== (i % B == 0)) begin
            n_fail++;
            $display("FAIL random_beat%0d: got %h sof=%b expected %h sof=%b", i, obs_d[i],
                     obs_s[i], exp_beat(i / B, i % B), (i % B == 0));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_gapped();
      test_random_gaps();
      test_extremes();
      test_mid_sof();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
